// File: rtl/pipeline_control_unit.sv
// rtl/pipeline_control_unit.sv - stall/flush sequencer driving every pipeline register enable and flush
// Optional perf counters (stall_cycles, flush_count) are built when PIPE_PERF_CNT_EN is defined.
module pipeline_control_unit #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int PERF_W         = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_use_stall,
  input  logic imem_ready,
  input  logic dmem_req_mem,
  input  logic dmem_ready,
  input  logic muldiv_start_ex,
  input  logic muldiv_done,
  input  logic branch_taken_ex,
  output logic pc_we,
  output logic if_id_we,
  output logic id_ex_we,
  output logic ex_mem_we,
  output logic mem_wb_we,
  output logic if_id_flush,
  output logic id_ex_flush,
  output logic ex_mem_flush,
  output logic mem_wb_flush,
  output logic muldiv_issue,
  output logic timeout_err
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
`endif
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_ISSUE = 2'd1,
    MD_WAIT  = 2'd2
  } state_t;

  state_t        state;
  logic          done_pending;
  logic [CW-1:0] wait_cnt;
  logic          dfreeze;
  logic          md_complete;

  assign dfreeze     = dmem_req_mem & ~dmem_ready;
  assign md_complete = (state == MD_WAIT) & (muldiv_done | done_pending) & ~dfreeze;

  // A data-memory freeze outranks everything; otherwise the FSM state and RUN priorities decide.
  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    id_ex_we     = 1'b1;
    ex_mem_we    = 1'b1;
    mem_wb_we    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    muldiv_issue = 1'b0;
    if (dfreeze) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      mem_wb_flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (muldiv_start_ex) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            ex_mem_flush = 1'b1;
          end else if (branch_taken_ex) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use_stall) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
          end else if (!imem_ready) begin
            pc_we       = 1'b0;
            if_id_flush = 1'b1;
          end
        end
        MD_ISSUE: begin
          pc_we        = 1'b0;
          if_id_we     = 1'b0;
          id_ex_we     = 1'b0;
          ex_mem_flush = 1'b1;
          muldiv_issue = 1'b1;
        end
        MD_WAIT: begin
          pc_we        = 1'b0;
          if_id_we     = 1'b0;
          id_ex_we     = 1'b0;
          ex_mem_flush = ~md_complete;
        end
        default: begin
          pc_we = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      done_pending <= 1'b0;
      wait_cnt     <= '0;
      timeout_err  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (!dfreeze && muldiv_start_ex) state <= MD_ISSUE;
        end
        MD_ISSUE: begin
          if (!dfreeze) state <= MD_WAIT;
        end
        MD_WAIT: begin
          if (md_complete) begin
            state        <= RUN;
            done_pending <= 1'b0;
          end else if (muldiv_done) begin
            done_pending <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
      // Watchdog: counts consecutive frozen or mul/div-waiting cycles, saturating at the limit.
      if (dfreeze || state == MD_WAIT) begin
        if (wait_cnt == WAIT_MAX) timeout_err <= 1'b1;
        else                      wait_cnt    <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_we) stall_cycles <= stall_cycles + 1'b1;
      if (branch_taken_ex && !dfreeze && state == RUN) flush_count <= flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
// tb/tb_pipeline_control_unit.sv - directed plus randomized checks against a stage-hold reference model
module tb_pipeline_control_unit;

  localparam int T  = 8;
  localparam int PW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_use_stall = 0, imem_ready = 1, dmem_req_mem = 0, dmem_ready = 1;
  logic muldiv_start_ex = 0, muldiv_done = 0, branch_taken_ex = 0;
  logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, muldiv_issue, timeout_err;
`ifdef PIPE_PERF_CNT_EN
  logic [PW-1:0] stall_cycles, flush_count;
`endif

  pipeline_control_unit #(.TIMEOUT_CYCLES(T), .PERF_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_use_stall(load_use_stall), .imem_ready(imem_ready),
    .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
    .muldiv_start_ex(muldiv_start_ex), .muldiv_done(muldiv_done),
    .branch_taken_ex(branch_taken_ex),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
    .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .muldiv_issue(muldiv_issue), .timeout_err(timeout_err)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: mul/div phase 0=none, 1=awaiting issue, 2=in flight.
  int            m_md;
  logic          m_pend;
  int            m_wait;
  logic          m_err;
  logic [PW-1:0] m_stall, m_flush;

  // Input bundle order: {lu, imem, req, rdy, start, done, br}
  localparam logic [6:0] IDLE = 7'b0101000;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] model_out(input logic [6:0] v);
    int hold;
    logic [4:0] bub;
    logic [4:0] we;
    logic iss;
    logic df;
    df   = v[4] & ~v[3];
    hold = 0;
    bub  = '0;
    iss  = 1'b0;
    if (df) begin
      hold = 4; bub[4] = 1'b1;
    end else if (m_md != 0) begin
      hold   = 3;
      bub[3] = !(m_md == 2 && (v[1] || m_pend));
      iss    = (m_md == 1);
    end else if (v[2]) begin
      hold = 3; bub[3] = 1'b1;
    end else if (v[0]) begin
      bub[1] = 1'b1; bub[2] = 1'b1;
    end else if (v[6]) begin
      hold = 2; bub[2] = 1'b1;
    end else if (!v[5]) begin
      hold = 1; bub[1] = 1'b1;
    end
    for (int i = 0; i < 5; i++) we[i] = (i >= hold) || bub[i];
    return {we[0], we[1], we[2], we[3], we[4], bub[1], bub[2], bub[3], bub[4], iss, m_err};
  endfunction

  task automatic model_step(input logic [6:0] v, input logic [10:0] exp);
    logic df;
    logic comp;
    df   = v[4] & ~v[3];
    comp = (m_md == 2) && (v[1] || m_pend) && !df;
    if (df || m_md == 2) begin
      if (m_wait == T - 1) m_err = 1'b1;
      else                 m_wait++;
    end else begin
      m_wait = 0;
    end
    if (!exp[10]) m_stall = m_stall + 1;
    if (v[0] && !df && m_md == 0) m_flush = m_flush + 1;
    if (m_md == 0 && !df && v[2]) m_md = 1;
    else if (m_md == 1 && !df) m_md = 2;
    else if (m_md == 2) begin
      if (comp) begin m_md = 0; m_pend = 1'b0; end
      else if (v[1]) m_pend = 1'b1;
    end
  endtask

  function automatic logic [10:0] dut_vec();
    return {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
            if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, muldiv_issue, timeout_err};
  endfunction

  task automatic apply(input logic [6:0] v);
    {load_use_stall, imem_ready, dmem_req_mem, dmem_ready, muldiv_start_ex, muldiv_done, branch_taken_ex} = v;
  endtask

  task automatic step(input logic [6:0] v, output logic [10:0] obs);
    logic [10:0] exp;
    @(negedge clk);
    apply(v);
    #1;
    exp = model_out(v);
    obs = dut_vec();
    check_eq("ctl", {53'd0, obs}, {53'd0, exp});
`ifdef PIPE_PERF_CNT_EN
    check_eq("stall_cycles", {32'd0, stall_cycles}, {32'd0, m_stall});
    check_eq("flush_count", {32'd0, flush_count}, {32'd0, m_flush});
`endif
    @(posedge clk);
    model_step(v, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    apply(IDLE);
    rst_n = 1'b0;
    m_md = 0; m_pend = 1'b0; m_wait = 0; m_err = 1'b0; m_stall = '0; m_flush = '0;
    #1;
    check_eq("reset_ctl", {53'd0, dut_vec()}, {53'd0, 11'b11111_0000_0_0});
`ifdef PIPE_PERF_CNT_EN
    check_eq("reset_stall", {32'd0, stall_cycles}, 64'd0);
    check_eq("reset_flush", {32'd0, flush_count}, 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [10:0] o;
    logic [6:0]  v;
    int n_iss, n_pc, iss_at, n_mwf;

    do_reset();
    for (int c = 0; c < 10; c++) begin
      step(IDLE, o);
      check_eq("idle", {53'd0, o}, {53'd0, 11'b11111_0000_0_0});
    end

    step(7'b1101000, o);
    check_eq("lu_stall", {61'd0, o[10], o[9], o[4]}, {61'd0, 3'b001});
    step(IDLE, o);
    step(7'b0101001, o);
    check_eq("branch", {61'd0, o[10], o[5], o[4]}, {61'd0, 3'b111});
    step(7'b1101001, o);
    check_eq("branch_over_lu", {61'd0, o[10], o[5], o[4]}, {61'd0, 3'b111});

    // mul/div: start held, done 5 cycles after the issue pulse
    do_reset();
    n_iss = 0; n_pc = 0; iss_at = -1;
    for (int c = 0; c < 10; c++) begin
      v = IDLE;
      if (c <= 6) v[2] = 1'b1;
      if (c == 6) v[1] = 1'b1;
      step(v, o);
      if (o[1]) begin n_iss++; iss_at = c; end
      if (!o[10]) n_pc++;
      if (c == 6) check_eq("md_done_exmem", {62'd0, o[7], o[3]}, {62'd0, 2'b10});
      if (c == 7) check_eq("md_back_run", {63'd0, o[10]}, 64'd1);
    end
    check_eq("md_issue_cnt", n_iss, 1);
    check_eq("md_issue_at", iss_at, 1);
    check_eq("md_pc_hold", n_pc, 7);

    // done arrives during a 3-cycle data freeze
    do_reset();
    n_mwf = 0;
    for (int c = 0; c < 9; c++) begin
      v = IDLE;
      if (c <= 6) v[2] = 1'b1;
      if (c >= 3 && c <= 5) begin v[4] = 1'b1; v[3] = 1'b0; end
      if (c == 4) v[1] = 1'b1;
      step(v, o);
      if (o[2]) n_mwf++;
      if (c == 6) check_eq("pend_complete", {61'd0, o[7], o[3], o[2]}, {61'd0, 3'b100});
      if (c == 7) check_eq("pend_back_run", {63'd0, o[10]}, 64'd1);
    end
    check_eq("pend_memwb_flush", n_mwf, 3);

    // watchdog with dfreeze held for 10 cycles
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step(7'b0110000, o);
      if (c == 7) check_eq("wd_before", {63'd0, o[0]}, 64'd0);
      if (c == 8) check_eq("wd_rise", {63'd0, o[0]}, 64'd1);
    end
    for (int c = 0; c < 3; c++) begin
      step(IDLE, o);
      check_eq("wd_sticky", {63'd0, o[0]}, 64'd1);
    end

`ifdef PIPE_PERF_CNT_EN
    do_reset();
    for (int k = 0; k < 3; k++) begin step(7'b1101000, o); step(IDLE, o); end
    for (int k = 0; k < 2; k++) begin step(7'b0101001, o); step(IDLE, o); end
    check_eq("perf_stall3", {32'd0, stall_cycles}, 64'd3);
    check_eq("perf_flush2", {32'd0, flush_count}, 64'd2);
    do_reset();
`endif

    // randomized traffic with occasional resets, including mid mul/div
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if (c % 97 == 96) do_reset();
      v[6] = ($urandom_range(0, 99) < 20);
      v[5] = ($urandom_range(0, 99) < 80);
      v[4] = ($urandom_range(0, 99) < 30);
      v[3] = ($urandom_range(0, 99) < 50);
      v[2] = ($urandom_range(0, 99) < 12);
      v[1] = ($urandom_range(0, 99) < 25);
      v[0] = ($urandom_range(0, 99) < 15);
      step(v, o);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
